// File: rtl/imem_pkg.sv
// Shared instruction-memory definitions: loader states, word geometry and
// the default memory size also used by the instruction memory itself.
package imem_pkg;

  localparam int WORD_BYTES = 4;
  localparam int LANE_W     = 2;
  localparam int IMEM_BYTES = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE,
    S_ERROR
  } loader_state_t;

endpackage

// File: rtl/imem_byte_packer.sv
// Packs a little-endian byte stream into one 32-bit word.
// Tracks the current lane and accumulates the byte enables.
module imem_byte_packer
  import imem_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    load,
  input  logic [7:0]              byte_data,
  output logic [LANE_W-1:0]       lane,
  output logic [8*WORD_BYTES-1:0] data,
  output logic [WORD_BYTES-1:0]   be
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lane <= '0;
      data <= '0;
      be   <= '0;
    end else if (load) begin
      data[{lane, 3'b000} +: 8] <= byte_data;
      be[lane]                  <= 1'b1;
      lane                      <= lane + 1'b1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction memory writer: collects bytes into words, writes them from
// BASE_ADDR upwards and holds the core in reset until the image is loaded.
//
//   state     | meaning
//   S_IDLE    | waiting for start, core held
//   S_COLLECT | accepting bytes into the current word
//   S_WRITE   | presenting the packed word until wr_ready
//   S_DONE    | image loaded, core released
//   S_ERROR   | image exceeded memory capacity, core held
module imem_loader
  import imem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned MEM_BYTES = IMEM_BYTES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        byte_last,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_be,
  input  logic        wr_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_hold,
  output logic [31:0] byte_count
);

  localparam logic [31:0] MEM_LIMIT = MEM_BYTES;

  loader_state_t     state;
  logic              last_seen;
  logic [LANE_W-1:0] lane;
  logic              start_ok;
  logic              xfer;
  logic              full;
  logic              pk_load;
  logic              pk_clear;

  assign start_ok = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
  assign xfer     = byte_valid && byte_ready;
  assign full     = (byte_count == MEM_LIMIT);
  assign pk_load  = xfer && !full;
  // The final word stays visible on wr_data after the load completes.
  assign pk_clear = start_ok || (state == S_WRITE && wr_ready && !last_seen);

  imem_byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (pk_clear),
    .load      (pk_load),
    .byte_data (byte_data),
    .lane      (lane),
    .data      (wr_data),
    .be        (wr_be)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= BASE_ADDR;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      cpu_hold   <= 1'b1;
      byte_count <= '0;
      last_seen  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start_ok) begin
            state      <= S_COLLECT;
            byte_ready <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_hold   <= 1'b1;
            wr_addr    <= BASE_ADDR;
            byte_count <= '0;
            last_seen  <= 1'b0;
          end
        end
        S_COLLECT: begin
          if (xfer) begin
            if (full) begin
              state      <= S_ERROR;
              byte_ready <= 1'b0;
              busy       <= 1'b0;
              error      <= 1'b1;
            end else begin
              byte_count <= byte_count + 32'd1;
              if (lane == 2'd3 || byte_last) begin
                state      <= S_WRITE;
                byte_ready <= 1'b0;
                wr_en      <= 1'b1;
                last_seen  <= byte_last;
              end
            end
          end
        end
        S_WRITE: begin
          if (wr_ready) begin
            wr_en <= 1'b0;
            if (last_seen) begin
              state    <= S_DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state      <= S_COLLECT;
              byte_ready <= 1'b1;
              wr_addr    <= wr_addr + 32'd4;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: images are driven with random valid and
// wr_ready gaps and the captured writes are compared to a word-level model.
module tb_imem_loader;

  localparam int MEM = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_last = 1'b0;
  logic        wr_ready = 1'b0;
  logic        byte_ready, wr_en, busy, done, error, cpu_hold;
  logic [31:0] wr_addr, wr_data, byte_count;
  logic [3:0]  wr_be;

  imem_loader #(.BASE_ADDR(32'h0), .MEM_BYTES(MEM)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_be      (wr_be),
    .wr_ready   (wr_ready),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .cpu_hold   (cpu_hold),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  img [0:63];
  logic [31:0] got_addr [$];
  logic [31:0] got_data [$];
  logic [3:0]  got_be   [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: bytes actually stored are the first min(n, MEM) of the image.
  function automatic int stored(input int n);
    return (n > MEM) ? MEM : n;
  endfunction

  function automatic logic [31:0] exp_data(input int j, input int n);
    logic [31:0] d = 32'h0;
    for (int b = 0; b < 4; b++)
      if (4 * j + b < stored(n)) d = d | (32'(img[4 * j + b]) << (8 * b));
    return d;
  endfunction

  function automatic logic [3:0] exp_be(input int j, input int n);
    logic [3:0] e = 4'h0;
    for (int b = 0; b < 4; b++)
      if (4 * j + b < stored(n)) e = e | (4'h1 << b);
    return e;
  endfunction

  task automatic run_load(input string name, input int n, input int stall);
    int idx = 0;
    int stall_left = stall;
    bit fin = 1'b0;
    int nwords;
    got_addr.delete();
    got_data.delete();
    got_be.delete();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk($sformatf("%s hold_after_start", name), 32'(cpu_hold), 32'd1);
    chk($sformatf("%s busy_after_start", name), 32'(busy), 32'd1);
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      @(negedge clk);
      if (done || error) begin
        fin = 1'b1;
      end else begin
        byte_valid = (idx < n) && ($urandom_range(0, 3) != 0);
        byte_data  = (idx < n) ? img[idx] : 8'h00;
        byte_last  = (idx == n - 1);
        if (wr_en && stall_left > 0) begin
          wr_ready = 1'b0;
          stall_left--;
          chk($sformatf("%s stall_ready", name), 32'(byte_ready), 32'd0);
          chk($sformatf("%s stall_addr", name), wr_addr, 32'(4 * got_addr.size()));
          chk($sformatf("%s stall_data", name), wr_data, exp_data(got_addr.size(), n));
          chk($sformatf("%s stall_be", name), 32'(wr_be), 32'(exp_be(got_addr.size(), n)));
        end else begin
          wr_ready = ($urandom_range(0, 2) != 0);
        end
        if (byte_valid && byte_ready) idx++;
        if (wr_en && wr_ready) begin
          got_addr.push_back(wr_addr);
          got_data.push_back(wr_data);
          got_be.push_back(wr_be);
        end
      end
    end
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    wr_ready   = 1'b0;
    chk($sformatf("%s finished", name), 32'(fin), 32'd1);
    nwords = (stored(n) + 3) / 4;
    chk($sformatf("%s nwrites", name), 32'(got_addr.size()), 32'(nwords));
    for (int j = 0; j < got_addr.size() && j < nwords; j++) begin
      chk($sformatf("%s addr[%0d]", name, j), got_addr[j], 32'(4 * j));
      chk($sformatf("%s data[%0d]", name, j), got_data[j], exp_data(j, n));
      chk($sformatf("%s be[%0d]", name, j), 32'(got_be[j]), 32'(exp_be(j, n)));
    end
    chk($sformatf("%s byte_count", name), byte_count, 32'(stored(n)));
    chk($sformatf("%s done", name), 32'(done), 32'(n <= MEM));
    chk($sformatf("%s error", name), 32'(error), 32'(n > MEM));
    chk($sformatf("%s cpu_hold", name), 32'(cpu_hold), 32'(n > MEM));
  endtask

  task automatic set_img(input logic [63:0] b, input int n);
    for (int i = 0; i < n; i++) img[i] = b[8 * i +: 8];
  endtask

  int rn;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst byte_ready", 32'(byte_ready), 32'd0);
    chk("rst wr_en", 32'(wr_en), 32'd0);
    chk("rst wr_addr", wr_addr, 32'h0);
    chk("rst wr_data", wr_data, 32'h0);
    chk("rst wr_be", 32'(wr_be), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst error", 32'(error), 32'd0);
    chk("rst cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst byte_count", byte_count, 32'd0);
    reset = 1'b0;

    // byte i of the image sits at bits [8i+7:8i]
    set_img(64'h0000_0000_0094_0333, 4);
    run_load("one_word", 4, 0);
    set_img(64'h4139_03b3_0094_0333, 8);
    run_load("two_words", 8, 0);
    set_img(64'h0000_5a6c_0094_0333, 6);
    run_load("partial", 6, 0);
    set_img(64'h4139_03b3_0094_0333, 8);
    run_load("stall", 8, 5);

    for (int i = 0; i < 64; i++) img[i] = 8'($urandom);
    run_load("overflow", 33, 0);
    run_load("after_error", 32, 0);

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 64; i++) img[i] = 8'($urandom);
      rn = $urandom_range(1, MEM);
      run_load($sformatf("rand%0d_n%0d", t, rn), rn, (t == 3) ? 3 : 0);
    end

    // Mid-transfer reset, with a start pulse during COLLECT that must be ignored
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    byte_valid = 1'b1;
    byte_data  = 8'hab;
    @(negedge clk) byte_data = 8'hcd;
    @(negedge clk) byte_valid = 1'b0;
    chk("midrst count2", byte_count, 32'd2);
    chk("midrst be2", 32'(wr_be), 32'h3);
    chk("midrst data2", wr_data, 32'h0000_cdab);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("ignored_start count", byte_count, 32'd2);
    chk("ignored_start ready", 32'(byte_ready), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst wr_en", 32'(wr_en), 32'd0);
    chk("midrst hold", 32'(cpu_hold), 32'd1);
    chk("midrst ready", 32'(byte_ready), 32'd0);
    chk("midrst be", 32'(wr_be), 32'd0);
    reset = 1'b0;
    byte_valid = 1'b1;
    byte_data  = 8'h11;
    byte_last  = 1'b1;
    wr_ready   = 1'b1;
    rn = 0;
    repeat (6) begin
      @(negedge clk);
      if (wr_en) rn++;
    end
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    wr_ready   = 1'b0;
    chk("midrst no_write", 32'(rn), 32'd0);
    chk("midrst idle_count", byte_count, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
